// File: rtl/bpm_window_controller_if.sv
// Purpose : bundles the measurement control inputs and the published heart-rate outputs.
// Latency : none, wires only.
// Backpressure : none; outputs are level/strobe signals with no ready handshake.
// Ports   : run, peak_in (towards the controller); bpm, bcd_hund/tens/ones, bpm_valid,
//           busy, sat (from the controller). master = stimulus/consumer side, slave = controller.
interface bpm_window_controller_if;
  logic       run;
  logic       peak_in;
  logic [9:0] bpm;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       bpm_valid;
  logic       busy;
  logic       sat;

  modport master (
    output run, peak_in,
    input  bpm, bcd_hund, bcd_tens, bcd_ones, bpm_valid, busy, sat
  );

  modport slave (
    input  run, peak_in,
    output bpm, bcd_hund, bcd_tens, bcd_ones, bpm_valid, busy, sat
  );
endinterface

// File: rtl/bpm_window_controller.sv
// Purpose : counts peak_in rising edges per window, scales to BPM, converts to BCD and publishes.
// Latency : bpm_valid strobes 12 cycles after the window_end cycle (SCALE + 10x CONVERT + PUBLISH).
// Backpressure : none; bpm_valid is a one-cycle strobe and results hold until the next publish.
// Ports   : clk, reset (sync, active-high); bus.slave carries run/peak_in in and
//           bpm/bcd_*/bpm_valid/busy/sat out.
// Option  : define PEAK_REFRACTORY_EN to ignore edges within REFRACT_CYCLES of an accepted peak.
module bpm_window_controller #(
  parameter int unsigned WINDOW_CYCLES  = 400000000,
  parameter int unsigned BPM_MULT       = 6,
  parameter int unsigned REFRACT_CYCLES = 10000000
) (
  input logic                    clk,
  input logic                    reset,
  bpm_window_controller_if.slave bus
);
  localparam int unsigned    WCW      = $clog2(WINDOW_CYCLES);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SCALE, CONVERT, PUBLISH} state_t;
  state_t state_q, state_d;

  logic [WCW-1:0] win_q;
  logic           peak_prev_q;
  logic [7:0]     pk_cnt_q;
  logic [7:0]     pk_next;
  logic [7:0]     snap_q;
  logic           window_end;
  logic           pk_rise;
  logic           accept;
  logic [31:0]    prod;
  logic [9:0]     bin_q;
  logic [9:0]     sh_q;
  logic           sat_next_q;
  logic [3:0]     step_q;
  logic [11:0]    bcd_q;
  logic [11:0]    adj;
  logic [11:0]    bcd_step;
  logic [9:0]     bpm_q;
  logic [11:0]    bcd_out_q;
  logic           sat_q;

  // Parameter legality only; produces no logic.
  always_comb begin : param_check
    assert (WINDOW_CYCLES >= 16 && WINDOW_CYCLES < (1 << 29) && REFRACT_CYCLES >= 1);
  end

  assign window_end = bus.run && (win_q == WIN_LAST);
  assign pk_rise    = bus.run && bus.peak_in && !peak_prev_q;

`ifdef PEAK_REFRACTORY_EN
  localparam int unsigned RW = $clog2(REFRACT_CYCLES + 1);
  logic [RW-1:0] refr_q;

  assign accept = pk_rise && (refr_q == '0);

  // Free-running across window boundaries; only run=0 or reset clears it.
  always_ff @(posedge clk) begin
    if (reset || !bus.run) begin
      refr_q <= '0;
    end else if (accept) begin
      refr_q <= RW'(REFRACT_CYCLES - 1);
    end else if (refr_q != '0) begin
      refr_q <= refr_q - 1'b1;
    end
  end
`else
  assign accept = pk_rise;
`endif

  // Saturating count including this cycle's event, so a window_end-cycle peak
  // lands in the snapshot of the ending window.
  always_comb begin
    pk_next = pk_cnt_q;
    if (accept && pk_cnt_q != 8'hFF) pk_next = pk_cnt_q + 8'd1;
  end

  assign prod = 32'(snap_q) * BPM_MULT;

  // Double-dabble step: add 3 to any digit >= 5, then shift in the next binary MSB.
  always_comb begin
    adj = bcd_q;
    if (bcd_q[3:0]  >= 4'd5) adj[3:0]  = bcd_q[3:0]  + 4'd3;
    if (bcd_q[7:4]  >= 4'd5) adj[7:4]  = bcd_q[7:4]  + 4'd3;
    if (bcd_q[11:8] >= 4'd5) adj[11:8] = bcd_q[11:8] + 4'd3;
    bcd_step = (adj << 1) | {11'd0, sh_q[9]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (window_end) state_d = SCALE;
      SCALE:   state_d = CONVERT;
      CONVERT: if (step_q == 4'd9) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Dropping run abandons any conversion without publishing.
    if (!bus.run) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      peak_prev_q <= 1'b0;
      pk_cnt_q    <= '0;
      snap_q      <= '0;
      bin_q       <= '0;
      sh_q        <= '0;
      sat_next_q  <= 1'b0;
      step_q      <= '0;
      bcd_q       <= '0;
      bpm_q       <= '0;
      bcd_out_q   <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (!bus.run) begin
        win_q       <= '0;
        pk_cnt_q    <= '0;
        peak_prev_q <= 1'b0;
      end else begin
        peak_prev_q <= bus.peak_in;
        if (window_end) begin
          win_q    <= '0;
          snap_q   <= pk_next;
          pk_cnt_q <= '0;
        end else begin
          win_q    <= win_q + 1'b1;
          pk_cnt_q <= pk_next;
        end
      end

      case (state_q)
        SCALE: begin
          if (prod > 32'd999) begin
            bin_q      <= 10'd999;
            sh_q       <= 10'd999;
            sat_next_q <= 1'b1;
          end else begin
            bin_q      <= prod[9:0];
            sh_q       <= prod[9:0];
            sat_next_q <= 1'b0;
          end
          bcd_q  <= '0;
          step_q <= '0;
        end
        CONVERT: begin
          bcd_q  <= bcd_step;
          sh_q   <= sh_q << 1;
          step_q <= step_q + 4'd1;
          // Results become visible in PUBLISH, alongside the strobe.
          if (step_q == 4'd9 && bus.run) begin
            bpm_q     <= bin_q;
            bcd_out_q <= bcd_step;
            sat_q     <= sat_next_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bpm       = bpm_q;
  assign bus.bcd_hund  = bcd_out_q[11:8];
  assign bus.bcd_tens  = bcd_out_q[7:4];
  assign bus.bcd_ones  = bcd_out_q[3:0];
  assign bus.sat       = sat_q;
  assign bus.bpm_valid = (state_q == PUBLISH);
  assign bus.busy      = (state_q != IDLE);
endmodule
